serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
//  Inverse-operation companion to the combinational full adder.
//  Uses one full-subtractor cell plus a borrow flip-flop.
//  Sits in the datapath lab as a small sequential ALU op with a start/done handshake.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (legal: WIDTH >= 2)
// PORTS
//  clk    in   1      rising-edge clock (single clock domain)
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  minuend; sampled on the edge that accepts start
//  b      in   WIDTH  subtrahend; sampled on the edge that accepts start
//  busy   out  1      high while state == RUN
//  done   out  1      one-cycle pulse, high while state == DONE
//  diff   out  WIDTH  result, registered; holds until next completion
//  bout   out  1      final borrow out; 1 iff a < b (unsigned)
//  ovf    out  1      signed overflow: borrow into MSB XOR borrow out of MSB
// BEHAVIOUR
//  - Reset (rst_n low, any time, async): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0.
//    Internal shift registers, borrow flop and bit counter are cleared.
//  - FSM has three states:
//    IDLE -> RUN on start=1. On that edge: load sa<=a, sb<=b, br<=0, cnt<=0.
//    RUN  -> RUN each edge while cnt < WIDTH-1. On every RUN edge:
//            d   = sa[0]^sb[0]^br
//            bo  = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
//            sd  <= {d, sd[WIDTH-1:1]}
//            sa, sb >> 1
//            br  <= bo
//            cnt <= cnt+1
//    RUN  -> DONE on the edge that processes bit WIDTH-1 (cnt == WIDTH-1). On that edge:
//            diff <= {d, sd[WIDTH-1:1]}, bout <= bo, ovf <= br ^ bo.
//    DONE -> IDLE unconditionally on the next edge.
//  - Latency: accept edge E0; bits processed on E1..E_WIDTH.
//    done is high in the cycle after E_WIDTH; busy is high from after E0 through E_WIDTH.
//  - start while RUN or DONE is ignored; a and b are not re-sampled.
//    A start held continuously re-launches from IDLE: one idle cycle between jobs.
//  - diff, bout and ovf change only on the RUN->DONE edge or on reset.
//  - Width rules:
//    cnt is $clog2(WIDTH) bits and never wraps past WIDTH-1.
//    Arithmetic is modulo 2^WIDTH.
//    bout is the unsigned borrow; ovf is the signed overflow flag.
//  - Reset mid-RUN aborts the operation. No done pulse; outputs return to reset values.
// STRUCTURE
//  - Package serial_sub_pkg holds:
//    state localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//    CNT_W = $clog2(WIDTH) helper.
//  - Sub-module full_subtractor (ports: d, bout, a, b, bin), purely combinational.
//    Instantiated once for the per-bit d/bo computation.
//  - Top level holds the FSM, counter, shift registers and output registers.
// TESTING (WIDTH=8)
//  - a=8'd100, b=8'd58, 1-cycle start -> done 8 cycles after accept edge;
//    diff=8'h2A, bout=0, ovf=0.
//  - a=8'd5, b=8'd10 -> diff=8'hFB, bout=1, ovf=0.
//  - a=8'h80, b=8'h01 -> diff=8'h7F, bout=0, ovf=1.
//    a=8'h7F, b=8'hFF -> diff=8'h80, bout=1, ovf=1.
//  - Start with a=8'd9, b=8'd3; pulse start with a=0, b=0 on the 3rd RUN cycle
//    -> ignored; diff=8'h06; exactly one done pulse.
//  - rst_n low for 1 cycle at the 4th RUN cycle -> busy=0, done never pulses,
//    diff/bout/ovf=0; a new start afterwards completes correctly.
//  - start held high for 30 cycles, a=b=8'hFF -> diff=0, bout=0, ovf=0 every job;
//    done pulses every 10 cycles.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared constants for the bit-serial subtractor:
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - cnt_w(): width of the bit counter for a given operand width
package serial_sub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   Single-bit combinational full subtractor: d = a - b - bin.
//   Ports:
//     d    out 1  difference bit
//     bout out 1  borrow out
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they tie and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit
//   per clock, with a start/done handshake.
//   Ports:
//     clk    in  1      rising-edge clock
//     rst_n  in  1      asynchronous active-low reset
//     start  in  1      request, sampled only in IDLE
//     a      in  WIDTH  minuend, captured on the accepting edge
//     b      in  WIDTH  subtrahend, captured on the accepting edge
//     busy   out 1      high while a subtraction is in progress
//     done   out 1      one-cycle completion pulse
//     diff   out WIDTH  registered result, held until the next completion
//     bout   out 1      unsigned borrow out (a < b)
//     ovf    out 1      signed overflow (borrow into MSB ^ borrow out of MSB)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Collects the first WIDTH-1 result bits; the final bit goes straight to diff.
  logic [WIDTH-2:0] sd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] sd_full;

  full_subtractor u_fs (
    .d    (d_bit),
    .bout (bo_bit),
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br)
  );

  // Newest bit enters at the MSB; after the last bit this is the whole result.
  assign sd_full = {d_bit, sd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sd <= sd_full[WIDTH-1:1];
          sa <= sa >> 1;
          sb <= sb >> 1;
          br <= bo_bit;
          if (cnt == CNT_LAST) begin
            diff  <= sd_full;
            bout  <= bo_bit;
            // br is the borrow into the MSB, bo_bit the borrow out of it.
            ovf   <= br ^ bo_bit;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus the textbook overflow rule
  // (operands of different sign and a result whose sign differs from a).
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [W-1:0] md;
    logic         mbo;
    logic         mov;
    md  = ma - mb;
    mbo = (ma < mb);
    mov = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    return {mbo, mov, md};
  endfunction

  // Launch one job with a single-cycle start, wait for done and check it.
  task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
    logic [W+1:0] exp;
    int cyc;
    exp = model(ta, tb_v);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, 32'd8);
    check_eq({tag, "_diff"}, 32'(diff), 32'(exp[W-1:0]));
    check_eq({tag, "_bout"}, 32'(bout), 32'(exp[W+1]));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp[W]));
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin : main
    int dones;
    int last_done;
    logic [W+1:0] exp;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_bout", 32'(bout), 32'd0);
    check_eq("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;

    // Directed vectors
    run_job(8'd100, 8'd58, "d100_58");
    run_job(8'd5,   8'd10, "d5_10");
    run_job(8'h80,  8'h01, "d80_01");
    run_job(8'h7F,  8'hFF, "d7f_ff");
    run_job(8'h00,  8'h00, "d00_00");
    run_job(8'h00,  8'h80, "d00_80");

    // Random vectors
    for (int i = 0; i < 30; i++) begin
      run_job(W'($urandom), W'($urandom), "rand");
    end

    // Start during RUN is ignored
    @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd0; b = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        check_eq("ign_diff", 32'(diff), 32'h06);
      end
      @(negedge clk);
    end
    check_eq("ign_dones", dones, 32'd1);

    // Reset in the middle of a run
    @(negedge clk);
    a = 8'd200; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_diff", 32'(diff), 32'd0);
    check_eq("mid_bout", 32'(bout), 32'd0);
    check_eq("mid_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("mid_nodone", dones, 32'd0);
    check_eq("mid_hold", 32'(diff), 32'd0);
    run_job(8'd77, 8'd200, "post_rst");

    // Start held high: back-to-back jobs, one idle cycle between
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    exp = model(8'hFF, 8'hFF);
    dones = 0;
    last_done = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (last_done >= 0) check_eq("held_period", i - last_done, 32'd10);
        last_done = i;
        check_eq("held_diff", 32'(diff), 32'(exp[W-1:0]));
        check_eq("held_bout", 32'(bout), 32'(exp[W+1]));
        check_eq("held_ovf",  32'(ovf),  32'(exp[W]));
      end
    end
    start = 1'b0;
    check_eq("held_dones", dones, 32'd3);
    repeat (12) @(negedge clk);
    check_eq("held_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
